// File: rtl/mdr_mem_port_if.sv
// Memory-side handshake of mdr_mem_port: word address, steered store data,
// byte enables and the variable-latency req/ack pair.
interface mdr_mem_port_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
) ();
   localparam int NB = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NB-1:0]         mem_be;
   logic                  mem_req;
   logic                  mem_we;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_be, mem_req, mem_we,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_be, mem_req, mem_we,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mdr_mem_port.sv
// MAR/MDR pair with a req/ack data-memory port: sized loads with extension,
// lane-steered stores, misalignment detection and an ack timeout.
module mdr_mem_port #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 9,
   parameter int                    TIMEOUT    = 15,
   parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic [DATA_WIDTH-1:0] BusMuxOut,
   input  logic                  MARin,
   input  logic                  MDRin,
   input  logic                  read,
   input  logic                  write,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   output logic [DATA_WIDTH-1:0] MDRout,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   mdr_mem_port_if.master        bus
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] mar;
   logic [DATA_WIDTH-1:0] mdr;
   logic [7:0]            cnt;
   logic                  err_q;
   logic [1:0]            size_q;
   logic                  sx_q;
   logic                  dir_q;
   logic [LB-1:0]         lane_eff;
   logic                  misaligned;
   logic                  in_req;

   // Shift the addressed byte/half down to bit 0 and extend it.
   function automatic logic [DATA_WIDTH-1:0] load_extract(
      input logic [DATA_WIDTH-1:0] rdata,
      input logic [1:0]            sz,
      input logic                  sx,
      input logic [LB-1:0]         lane
   );
      logic [DATA_WIDTH-1:0] shifted;
      logic [DATA_WIDTH-1:0] result;
      logic [LB-1:0]         sel;
      sel     = (sz == 2'b01) ? {lane[LB-1:1], 1'b0} : lane;
      shifted = rdata >> {sel, 3'b000};
      case (sz)
         2'b00:   result = {{(DATA_WIDTH-8){sx & shifted[7]}}, shifted[7:0]};
         2'b01:   result = {{(DATA_WIDTH-16){sx & shifted[15]}}, shifted[15:0]};
         default: result = rdata;
      endcase
      return result;
   endfunction

   function automatic logic [NB-1:0] store_be(
      input logic [1:0]    sz,
      input logic [LB-1:0] lane
   );
      logic [NB-1:0] be;
      case (sz)
         2'b00:   be = {{(NB-1){1'b0}}, 1'b1} << lane;
         2'b01:   be = {{(NB-2){1'b0}}, 2'b11} << {lane[LB-1:1], 1'b0};
         default: be = '1;
      endcase
      return be;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] store_data(
      input logic [1:0]            sz,
      input logic [DATA_WIDTH-1:0] data
   );
      logic [DATA_WIDTH-1:0] wd;
      case (sz)
         2'b00:   wd = {NB{data[7:0]}};
         2'b01:   wd = {(NB/2){data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

   // The alignment check sees a MAR value being loaded in the same cycle.
   assign lane_eff   = MARin ? BusMuxOut[LB-1:0] : mar[LB-1:0];
   assign misaligned = (size == 2'b01) ? lane_eff[0]
                     : (size[1] ? (lane_eff != '0) : 1'b0);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state  <= S_IDLE;
         mar    <= '0;
         mdr    <= INIT;
         cnt    <= '0;
         err_q  <= 1'b0;
         size_q <= 2'b00;
         sx_q   <= 1'b0;
         dir_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (MARin) mar <= BusMuxOut[ADDR_WIDTH-1:0];
               if (MDRin && !read) mdr <= BusMuxOut;
               if (read || write) begin
                  size_q <= size;
                  sx_q   <= sign_ext;
                  dir_q  <= write;
                  cnt    <= '0;
                  if ((read && write) || misaligned) begin
                     err_q <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     err_q <= 1'b0;
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (bus.mem_ack) begin
                  if (!dir_q) mdr <= load_extract(bus.mem_rdata, size_q, sx_q, mar[LB-1:0]);
                  state <= S_DONE;
               end else if (cnt == TO_LAST) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Memory-side outputs decode straight from state so reset drops them at once.
   assign in_req        = (state == S_REQ);
   assign bus.mem_req   = in_req;
   assign bus.mem_we    = in_req & dir_q;
   assign bus.mem_addr  = {mar[ADDR_WIDTH-1:LB], {LB{1'b0}}};
   assign bus.mem_be    = in_req ? store_be(size_q, mar[LB-1:0]) : '0;
   assign bus.mem_wdata = in_req ? store_data(size_q, mdr) : '0;

   assign MDRout = mdr;
   assign busy   = (state != S_IDLE);
   assign done   = (state == S_DONE);
   assign err    = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Scoreboard bench for mdr_mem_port: stimulus pushes expected transaction
// outcomes, a memory/monitor process answers requests and checks on done.
module tb_mdr_mem_port;
   localparam int          DW     = 32;
   localparam int          AW     = 9;
   localparam int          TO     = 15;
   localparam logic [31:0] INIT_V = 32'hC0DE_0001;

   typedef struct {
      logic        err;
      logic [31:0] mdr;
      int          req_cycles;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [8:0]  addr;
   } exp_t;

   logic        clock = 1'b0;
   logic        clear_n = 1'b0;
   logic [31:0] BusMuxOut = '0;
   logic        MARin = 1'b0, MDRin = 1'b0, read = 1'b0, write = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [31:0] MDRout;
   logic        busy, done, err;

   mdr_mem_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

   mdr_mem_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .INIT(INIT_V)) dut (
      .clock(clock), .clear_n(clear_n), .BusMuxOut(BusMuxOut), .MARin(MARin),
      .MDRin(MDRin), .read(read), .write(write), .size(size), .sign_ext(sign_ext),
      .MDRout(MDRout), .busy(busy), .done(done), .err(err), .bus(ifc)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [8:0]  m_mar = '0;
   logic [31:0] m_mdr = INIT_V;
   logic        m_err = 1'b0;
   int          ack_delay = 0;
   logic [31:0] rdata_val = '0;
   int          obs_req = 0, obs_lat = 0;
   logic [3:0]  obs_be;
   logic [31:0] obs_wdata;
   logic        obs_we;
   logic [8:0]  obs_addr;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [1:0] sz,
                                            input bit sx, input int lane);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (rd >> (8 * lane)) & 32'hFF;
         if (sx && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (rd >> (8 * ((lane / 2) * 2))) & 32'hFFFF;
         if (sx && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Memory responder plus scoreboard monitor.
   initial begin
      exp_t e;
      ifc.mem_ack = 1'b0;
      ifc.mem_rdata = '0;
      forever begin
         @(negedge clock);
         if (!clear_n) begin
            obs_req = 0;
            obs_lat = 0;
            ifc.mem_ack = 1'b0;
         end else begin
            if (busy) obs_lat++;
            if (done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'(done), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("done_err", 32'(err), 32'(e.err));
                  check("done_mdr", MDRout, e.mdr);
                  check("req_cycles", 32'(obs_req), 32'(e.req_cycles));
                  check("done_latency", 32'(obs_lat), 32'(e.req_cycles + 1));
                  if (e.req_cycles > 0) begin
                     check("mem_be", 32'(obs_be), 32'(e.be));
                     check("mem_wdata", obs_wdata, e.wdata);
                     check("mem_we", 32'(obs_we), 32'(e.we));
                     check("mem_addr", 32'(obs_addr), 32'(e.addr));
                  end
               end
               obs_req = 0;
               obs_lat = 0;
            end
            if (ifc.mem_req) begin
               obs_be    = ifc.mem_be;
               obs_wdata = ifc.mem_wdata;
               obs_we    = ifc.mem_we;
               obs_addr  = ifc.mem_addr;
               ifc.mem_ack   = (obs_req == ack_delay);
               ifc.mem_rdata = ifc.mem_ack ? rdata_val : $urandom;
               obs_req++;
            end else begin
               ifc.mem_ack   = 1'($urandom_range(0, 1));
               ifc.mem_rdata = $urandom;
            end
         end
      end
   end

   task automatic idle_inputs();
      MARin = 1'b0; MDRin = 1'b0; read = 1'b0; write = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clock);
      while (busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("idle_reached", 32'(busy), 32'd0);
      check("idle_err", 32'(err), 32'(m_err));
      check("idle_mdr", MDRout, m_mdr);
   endtask

   task automatic issue(input bit rd, input bit wr, input bit mdrin, input bit marin,
                        input logic [31:0] bv, input logic [1:0] sz, input bit sx,
                        input int dly, input logic [31:0] rdat);
      exp_t e;
      int   lane;
      bit   mis;
      wait_idle();
      if (marin) m_mar = bv[8:0];
      if (mdrin && !rd) m_mdr = bv;
      ack_delay = dly;
      rdata_val = rdat;
      MARin = marin; MDRin = mdrin; read = rd; write = wr;
      BusMuxOut = bv; size = sz; sign_ext = sx;
      if (rd || wr) begin
         lane = int'(m_mar % 9'd4);
         mis  = (sz == 2'd1 && (lane % 2) != 0) || (sz >= 2'd2 && lane != 0);
         e.addr  = 9'(int'(m_mar) - lane);
         e.we    = wr;
         e.be    = 4'hF;
         e.wdata = m_mdr;
         if (sz == 2'd0) begin
            e.be    = 4'(1 << lane);
            e.wdata = (m_mdr & 32'hFF) * 32'h0101_0101;
         end else if (sz == 2'd1) begin
            e.be    = 4'(3 << ((lane / 2) * 2));
            e.wdata = (m_mdr & 32'hFFFF) * 32'h0001_0001;
         end
         if ((rd && wr) || mis) begin
            e.err = 1'b1;
            e.req_cycles = 0;
         end else begin
            e.err = (dly >= TO);
            e.req_cycles = (dly < TO) ? dly + 1 : TO;
            if (rd && !e.err) m_mdr = load_val(rdat, sz, sx, lane);
         end
         e.mdr = m_mdr;
         m_err = e.err;
         sb.push_back(e);
      end
      @(posedge clock);
      #1 idle_inputs();
   endtask

   // Drive garbage loads and requests only while the DUT is busy.
   task automatic poke_busy(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (busy) begin
            MARin = 1'b1; MDRin = 1'b1; read = 1'b1; write = 1'($urandom_range(0, 1));
            BusMuxOut = $urandom; size = 2'($urandom);
         end else begin
            idle_inputs();
         end
      end
      @(posedge clock);
      #1 idle_inputs();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bv;
      logic [1:0]  sz;
      int          op, dly;
      bit          marin, sx;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_req", 32'(ifc.mem_req), 32'd0);
      check("rst_we", 32'(ifc.mem_we), 32'd0);
      check("rst_be", 32'(ifc.mem_be), 32'd0);
      check("rst_wdata", ifc.mem_wdata, 32'd0);
      check("rst_mdr", MDRout, INIT_V);
      check("rst_addr", 32'(ifc.mem_addr), 32'd0);
      @(negedge clock);
      clear_n = 1'b1;

      // Directed cases
      issue(1, 0, 0, 1, 32'h10, 2'd2, 0, 3, 32'hDEAD_BEEF);
      issue(1, 0, 0, 1, 32'h13, 2'd0, 1, 0, 32'h80FF_7F01);
      issue(1, 0, 0, 0, 32'h0, 2'd0, 0, 1, 32'h80FF_7F01);
      issue(1, 0, 0, 1, 32'h12, 2'd1, 1, 2, 32'h80FF_7F01);
      issue(0, 0, 1, 0, 32'h0000_00AB, 2'd0, 0, 0, 32'h0);
      issue(0, 1, 0, 1, 32'h21, 2'd0, 0, 2, 32'h0);
      issue(0, 1, 0, 1, 32'h22, 2'd1, 0, 0, 32'h0);
      issue(1, 0, 0, 1, 32'h02, 2'd2, 0, 0, 32'h1111_1111);
      issue(1, 0, 0, 1, 32'h44, 2'd2, 0, 1000, 32'h0);
      issue(1, 0, 0, 0, 32'h0, 2'd2, 0, 14, 32'h2468_ACE0);
      issue(1, 0, 0, 0, 32'h0, 2'd2, 0, TO, 32'h5A5A_5A5A);
      issue(1, 0, 0, 1, 32'h48, 2'd2, 0, 0, 32'h0F0F_0F0F);
      issue(1, 1, 0, 1, 32'h50, 2'd2, 0, 0, 32'h0);
      issue(1, 0, 1, 1, 32'h5555_AA10, 2'd2, 0, 1, 32'h1357_9BDF);
      issue(1, 0, 0, 1, 32'h30, 2'd2, 0, 5, 32'hCAFE_F00D);
      poke_busy(3);
      issue(0, 1, 0, 0, 32'h0, 2'd2, 0, 1, 32'h0);

      // Asynchronous reset in the middle of a request
      issue(1, 0, 0, 1, 32'h40, 2'd2, 0, 1000, 32'h0);
      repeat (4) @(negedge clock);
      check("pre_reset_req", 32'(ifc.mem_req), 32'd1);
      #2 clear_n = 1'b0;
      #1;
      check("arst_req", 32'(ifc.mem_req), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_mdr", MDRout, INIT_V);
      void'(sb.pop_back());
      m_mar = '0; m_mdr = INIT_V; m_err = 1'b0;
      repeat (2) @(posedge clock);
      #3 clear_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         op    = $urandom_range(0, 19);
         bv    = $urandom;
         if ($urandom_range(0, 2) != 0) bv[1:0] = 2'b00;
         marin = 1'($urandom_range(0, 1));
         sz    = 2'($urandom_range(0, 3));
         sx    = 1'($urandom_range(0, 1));
         dly   = ($urandom_range(0, 19) == 0) ? 1000 : $urandom_range(0, 4);
         if (op < 3)       issue(0, 0, 1, marin, bv, sz, sx, dly, $urandom);
         else if (op == 3) issue(1, 1, 0, marin, bv, sz, sx, dly, $urandom);
         else if (op < 12) issue(1, 0, (op == 4), marin, bv, sz, sx, dly, $urandom);
         else              issue(0, 1, 0, marin, bv, sz, sx, dly, $urandom);
      end

      wait_idle();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
